// File: rtl/pp3_mult_share_arbiter.sv
// pp3_mult_share_arbiter
// Round-robin front end that lets NUM_REQ fabric clients share one 32x32 hard
// multiplier for OP_W x OP_W products. One operation is in flight at a time:
// grant in IDLE, wait MULT_LAT cycles in MUL, hold the product in RESP until
// the granted client takes it.
module pp3_mult_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int OP_W     = 16,
  parameter int MULT_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_signed,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [31:0]             mult_a,
  output logic [31:0]             mult_b,
  output logic [1:0]              mult_vld,
  input  logic [63:0]             mult_c
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDXP_W = IDX_W + 1;
  localparam int CNT_W  = (MULT_LAT > 1) ? $clog2(MULT_LAT + 1) : 1;

  localparam logic [IDXP_W-1:0] NUM_REQ_C = IDXP_W'(NUM_REQ);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]  LAT_C     = CNT_W'(MULT_LAT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Widen an operand to the multiplier's 32-bit port: sign-replicate or zero-fill.
  function automatic logic [31:0] extend_op(input logic [OP_W-1:0] v, input logic is_signed);
    logic [31:0] r;
    if (is_signed) begin
      r = {{(32-OP_W){v[OP_W-1]}}, v};
    end else begin
      r = {{(32-OP_W){1'b0}}, v};
    end
    return r;
  endfunction

  logic [1:0]         state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   gnt_idx_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [31:0]        mult_a_r;
  logic [31:0]        mult_b_r;
  logic [1:0]         mult_vld_r;
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [31:0]        rsp_data_r;

  logic [IDXP_W-1:0]  cand_s;
  logic               hit_s;
  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [NUM_REQ-1:0] req_ready_s;

  // Upper half of the 64-bit product is never needed for OP_W-sized operands.
  logic unused_mult_hi_s;
  assign unused_mult_hi_s = ^mult_c[63:32];

  // Round-robin search: first valid requester starting at rr_ptr_r, wrapping.
  always_comb begin
    cand_s      = '0;
    hit_s       = 1'b0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + IDXP_W'(k);
      cand_s = (cand_s >= NUM_REQ_C) ? (cand_s - NUM_REQ_C) : cand_s;
      hit_s       = req_valid[cand_s[IDX_W-1:0]] & ~win_found_s;
      win_idx_s   = hit_s ? cand_s[IDX_W-1:0] : win_idx_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // Grant is combinational in IDLE and forced low while reset is asserted.
  always_comb begin
    req_ready_s = '0;
    if ((state_r == ST_IDLE) && win_found_s && rst_n) begin
      req_ready_s[win_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign mult_a    = mult_a_r;
  assign mult_b    = mult_b_r;
  assign mult_vld  = mult_vld_r;

  // Sequencer: accept a winner, count multiplier latency, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      gnt_idx_r   <= '0;
      cnt_r       <= '0;
      mult_a_r    <= 32'h0000_0000;
      mult_b_r    <= 32'h0000_0000;
      mult_vld_r  <= 2'b00;
      rsp_valid_r <= '0;
      rsp_data_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            mult_a_r   <= extend_op(req_a[win_idx_s*OP_W +: OP_W], req_signed[win_idx_s]);
            mult_b_r   <= extend_op(req_b[win_idx_s*OP_W +: OP_W], req_signed[win_idx_s]);
            gnt_idx_r  <= win_idx_s;
            cnt_r      <= LAT_C;
            mult_vld_r <= 2'b01;
            state_r    <= ST_MUL;
          end else begin
            mult_vld_r <= 2'b00;
          end
        end
        ST_MUL: begin
          if (cnt_r == CNT_W'(1)) begin
            rsp_data_r  <= mult_c[31:0];
            rsp_valid_r <= ONE_HOT0 << gnt_idx_r;
            mult_vld_r  <= 2'b00;
            state_r     <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready[gnt_idx_r]) begin
            rsp_valid_r <= '0;
            rr_ptr_r    <= (gnt_idx_r == LAST_IDX) ? '0 : (gnt_idx_r + IDX_W'(1));
            state_r     <= ST_IDLE;
          end else begin
            rsp_valid_r <= rsp_valid_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          mult_vld_r  <= 2'b00;
          rsp_valid_r <= '0;
        end
      endcase
    end
  end

endmodule
